// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side packer: FSM encoding and the
// default lane geometry.
package fifo_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int LANES_DEF = 4;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_rd_packer.sv
// Drains bytes from an async FIFO read port and packs LANES of them,
// little-endian, into one word presented on a valid/ready output.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LANES = LANES_DEF
) (
    input  logic                     rclk,
    input  logic                     rst,
    input  logic                     empty,
    input  logic                     underflow,
    input  logic [WIDTH-1:0]         rdata,
    output logic                     ren,
    output logic [WIDTH*LANES-1:0]   out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              word_count,
    output logic                     err_underflow
);

    localparam int            CW      = $clog2(LANES + 1);
    localparam logic [CW:0]   LANES_W = (CW + 1)'(LANES);
    localparam logic [CW-1:0] LAST    = CW'(LANES - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     cap_vld;
    logic [CW-1:0]            fill_cnt;
    logic [CW:0]              inflight;
    logic [WIDTH*LANES-1:0]   lanes_q;
    logic [WIDTH*LANES-1:0]   cap_word;
    logic [15:0]              word_count_q;
    logic                     out_free;
    logic                     word_done;
    logic                     load_out;

    assign out_free   = !out_valid || out_ready;
    assign word_done  = cap_vld && (fill_cnt == LAST);
    assign inflight   = {1'b0, fill_cnt} + {{CW{1'b0}}, cap_vld};
    assign load_out   = ((state == FILL) && word_done && out_free) ||
                        ((state == HOLD) && out_free);
    assign word_count = word_count_q;

    // Current lanes with the arriving byte merged into lane fill_cnt.
    always_comb begin
        cap_word = lanes_q;
        for (int k = 0; k < LANES; k++) begin
            if (fill_cnt == CW'(k)) begin
                cap_word[k*WIDTH +: WIDTH] = rdata;
            end
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (word_done && !out_free) state_nxt = HOLD;
            HOLD: if (out_free)               state_nxt = FILL;
            default:                          state_nxt = FILL;
        endcase
    end

    // Counting in-flight reads keeps the fetch from overrunning the word.
    always_comb begin
        ren = 1'b0;
        if (!rst && !empty && (state == FILL) && (inflight < LANES_W)) begin
            ren = 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            cap_vld       <= 1'b0;
            fill_cnt      <= '0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            word_count_q  <= '0;
            err_underflow <= 1'b0;
        end else begin
            cap_vld <= ren;
            if (underflow) begin
                err_underflow <= 1'b1;
            end
            if (out_valid && out_ready) begin
                word_count_q <= word_count_q + 16'd1;
            end
            if (load_out) begin
                out_valid <= 1'b1;
                out_data  <= (state == HOLD) ? lanes_q : cap_word;
                fill_cnt  <= '0;
            end else begin
                if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                end
                if (cap_vld) begin
                    fill_cnt <= fill_cnt + CW'(1);
                end
            end
        end
    end

    // Lane storage needs no reset: every lane is rewritten before it is used.
    always_ff @(posedge rclk) begin
        if (cap_vld) begin
            lanes_q <= cap_word;
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: a byte-queue FIFO model feeds the DUT
// and a monitor checks every accepted output word against expected words.
module tb_fifo_rd_packer;
    import fifo_pkg::*;

    logic        rclk = 1'b0;
    logic        rst;
    logic        empty = 1'b1;
    logic        underflow;
    logic [7:0]  rdata = 8'h00;
    logic        ren;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] word_count;
    logic        err_underflow;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  fifo_q[$];
    logic [31:0] exp_q[$];
    logic        acc_s = 1'b0;
    logic        acc_e;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.WIDTH(8), .LANES(4)) dut (
        .rclk          (rclk),
        .rst           (rst),
        .empty         (empty),
        .underflow     (underflow),
        .rdata         (rdata),
        .ren           (ren),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .word_count    (word_count),
        .err_underflow (err_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // FIFO model: a read accepted at an edge returns its byte shortly after.
    always @(negedge rclk) acc_s = ren && !empty;

    always @(posedge rclk) begin
        acc_e = acc_s;
        #2;
        if (acc_e && fifo_q.size() > 0) rdata = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
    end

    always @(negedge rclk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h required none", out_data);
            end else begin
                check("word", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge rclk);
            #1;
        end
    endtask

    task automatic wait_hs(input string name);
        bit found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge rclk);
            if (out_valid && out_ready) found = 1'b1;
        end
        if (!found) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got no handshake required one within 300 cycles", name);
        end
        @(posedge rclk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ren_cnt, ren_first, ren_last, vld_cnt;
        rst       = 1'b1;
        underflow = 1'b0;
        out_ready = 1'b1;

        // Reset state, with data already waiting so ren must be gated.
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
        fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
        exp_q.push_back(32'h44332211);
        cyc(3);
        @(negedge rclk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_word_count", 32'(word_count), 32'd0);
        check("rst_err", 32'(err_underflow), 32'd0);
        check("rst_ren", 32'(ren), 32'd0);
        @(posedge rclk); #1;
        rst = 1'b0;

        // Preloaded word, streaming with out_ready=1.
        ren_cnt = 0; ren_first = -1; ren_last = -1; vld_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge rclk);
            if (ren) begin
                ren_cnt++;
                if (ren_first < 0) ren_first = i;
                ren_last = i;
            end
            if (out_valid) vld_cnt++;
        end
        check("t1_ren_cycles", 32'(ren_cnt), 32'd4);
        check("t1_ren_span", 32'(ren_last - ren_first), 32'd3);
        check("t1_valid_cycles", 32'(vld_cnt), 32'd1);
        check("t1_word_count", 32'(word_count), 32'd1);

        // Backpressure: second word parks in HOLD.
        @(posedge rclk); #1;
        out_ready = 1'b0;
        for (int b = 1; b <= 8; b++) fifo_q.push_back(8'(b));
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        cyc(25);
        @(negedge rclk);
        check("t2_out_valid", 32'(out_valid), 32'd1);
        check("t2_held_data", out_data, 32'h04030201);
        check("t2_state", 32'(dut.state), 32'(HOLD));
        check("t2_ren", 32'(ren), 32'd0);
        @(posedge rclk); #1;
        out_ready = 1'b1;
        wait_hs("t2_first");
        wait_hs("t2_second");
        cyc(2);
        check("t2_valid_clear", 32'(out_valid), 32'd0);
        check("t2_word_count", 32'(word_count), 32'd3);

        // Partial word survives a long empty stretch.
        fifo_q.push_back(8'hA1); fifo_q.push_back(8'hA2);
        cyc(20);
        @(negedge rclk);
        check("t3_out_valid", 32'(out_valid), 32'd0);
        check("t3_ren", 32'(ren), 32'd0);
        @(posedge rclk); #1;
        fifo_q.push_back(8'hA3); fifo_q.push_back(8'hA4);
        exp_q.push_back(32'hA4A3A2A1);
        wait_hs("t3_word");
        check("t3_word_count", 32'(word_count), 32'd4);

        // Mid-word reset discards the partial lanes.
        fifo_q.push_back(8'h55); fifo_q.push_back(8'h66); fifo_q.push_back(8'h77);
        cyc(8);
        rst = 1'b1;
        cyc(2);
        @(negedge rclk);
        check("t4_out_valid", 32'(out_valid), 32'd0);
        check("t4_out_data", out_data, 32'h0);
        check("t4_word_count", 32'(word_count), 32'd0);
        check("t4_fill_cnt", 32'(dut.fill_cnt), 32'd0);
        @(posedge rclk); #1;
        rst = 1'b0;
        for (int b = 0; b < 4; b++) fifo_q.push_back(8'(8'h81 + b));
        exp_q.push_back(32'h84838281);
        wait_hs("t4_word");
        check("t4_word_count_after", 32'(word_count), 32'd1);

        // Sticky underflow error.
        check("t5_err_before", 32'(err_underflow), 32'd0);
        underflow = 1'b1;
        cyc(1);
        underflow = 1'b0;
        cyc(5);
        @(negedge rclk);
        check("t5_err_sticky", 32'(err_underflow), 32'd1);
        @(posedge rclk); #1;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge rclk);
        check("t5_err_cleared", 32'(err_underflow), 32'd0);

        // word_count wrap.
        force dut.word_count_q = 16'd65534;
        #1;
        release dut.word_count_q;
        check("t6_preset", 32'(word_count), 32'd65534);
        @(posedge rclk); #1;
        for (int b = 0; b < 8; b++) fifo_q.push_back(8'(8'hC1 + b));
        exp_q.push_back(32'hC4C3C2C1);
        exp_q.push_back(32'hC8C7C6C5);
        wait_hs("t6_first");
        check("t6_count_max", 32'(word_count), 32'd65535);
        wait_hs("t6_second");
        check("t6_count_wrap", 32'(word_count), 32'd0);

        cyc(5);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
